// File: rtl/neighbor_pkg.sv
// Shared definitions for the neighbour table and its consumers.
//   WORD_WIDTH    : width of every neighbour field (ID, hops, Q-value, energy)
//   MAX_NEIGHBORS : table depth
//   IDX_WIDTH     : width of a table index
//   sel_state_e   : next-hop selector state encoding
//   nbr_entry_t   : one neighbour table entry
//   last_index()  : index of the last entry to scan for a given populated count
package neighbor_pkg;

  localparam int WORD_WIDTH    = 16;
  localparam int MAX_NEIGHBORS = 32;
  localparam int IDX_WIDTH     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } sel_state_e;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] id;
    logic [WORD_WIDTH-1:0] hops;
    logic [WORD_WIDTH-1:0] qvalue;
    logic [WORD_WIDTH-1:0] energy;
    logic                  valid;
  } nbr_entry_t;

  // Last index to visit: min(count, MAX_NEIGHBORS) - 1. The count == 0 case
  // never starts a scan, so its (wrapped) value here is irrelevant.
  function automatic logic [IDX_WIDTH-1:0] last_index(
    input logic [WORD_WIDTH-1:0] count
  );
    if (count >= WORD_WIDTH'(MAX_NEIGHBORS))
      last_index = IDX_WIDTH'(MAX_NEIGHBORS - 1);
    else
      last_index = IDX_WIDTH'(count - WORD_WIDTH'(1));
  endfunction

endpackage

// File: rtl/nh_compare.sv
// Candidate-versus-best decision for the next-hop selector. Purely
// combinational.
//   cand       : entry currently presented by the neighbour table
//   best       : best entry held so far (only qvalue and hops matter)
//   has_best   : a best entry is currently held
//   min_energy : unsigned energy floor a candidate must meet
//   replace    : cand qualifies and should become the new best
module nh_compare
  import neighbor_pkg::*;
(
  input  nbr_entry_t            cand,
  input  nbr_entry_t            best,
  input  logic                  has_best,
  input  logic [WORD_WIDTH-1:0] min_energy,
  output logic                  replace
);

  logic qualifies;
  logic better;

  always_comb begin
    qualifies = cand.valid && (cand.energy >= min_energy);
    // Strictly better only: a full tie leaves the earlier index in place.
    better    = !has_best
             || (cand.qvalue > best.qvalue)
             || ((cand.qvalue == best.qvalue) && (cand.hops < best.hops));
    replace   = qualifies && better;
  end

  // Identity, energy and valid of the held best never influence ranking.
  logic unused_fields;
  assign unused_fields = ^{cand.id, best.id, best.energy, best.valid};

endmodule

// File: rtl/next_hop_selector.sv
// Next-hop selector: on request, walks the neighbour table one entry per
// clock through its index port and keeps the best qualifying neighbour
// (highest Q-value, then fewest hops, then lowest index). A candidate must be
// valid and meet the energy floor.
//   clk, nrst        : clock, asynchronous active-low reset
//   start            : scan request, honoured only in IDLE
//   hb_reset         : heartbeat reset, aborts a scan and clears the result
//   neighbor_count   : populated entries (clamped to MAX_NEIGHBORS, latched)
//   min_energy       : unsigned energy floor
//   neighborCount    : table read index
//   tbl_valid, mNode*: combinational read data for neighborCount
//   busy             : scan in progress
//   done             : one-cycle result-ready pulse
//   found, best_*    : selected neighbour, held until next start/hb_reset
module next_hop_selector
  import neighbor_pkg::*;
(
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  hb_reset,
  input  logic [WORD_WIDTH-1:0] neighbor_count,
  input  logic [WORD_WIDTH-1:0] min_energy,
  output logic [IDX_WIDTH-1:0]  neighborCount,
  input  logic                  tbl_valid,
  input  logic [WORD_WIDTH-1:0] mNodeID,
  input  logic [WORD_WIDTH-1:0] mNodeHops,
  input  logic [WORD_WIDTH-1:0] mNodeQValue,
  input  logic [WORD_WIDTH-1:0] mNodeEnergy,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [WORD_WIDTH-1:0] best_id,
  output logic [WORD_WIDTH-1:0] best_qvalue,
  output logic [WORD_WIDTH-1:0] best_hops,
  output logic [IDX_WIDTH-1:0]  best_idx
);

  sel_state_e           state;
  logic [IDX_WIDTH-1:0] last_idx;

  nbr_entry_t cand_entry;
  nbr_entry_t best_entry;
  logic       replace;

  always_comb begin
    cand_entry.id     = mNodeID;
    cand_entry.hops   = mNodeHops;
    cand_entry.qvalue = mNodeQValue;
    cand_entry.energy = mNodeEnergy;
    cand_entry.valid  = tbl_valid;
    best_entry.id     = best_id;
    best_entry.hops   = best_hops;
    best_entry.qvalue = best_qvalue;
    best_entry.energy = '0;
    best_entry.valid  = found;
  end

  nh_compare u_compare (
    .cand       (cand_entry),
    .best       (best_entry),
    .has_best   (found),
    .min_energy (min_energy),
    .replace    (replace)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= IDLE;
      last_idx      <= '0;
      neighborCount <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      found         <= 1'b0;
      best_id       <= '0;
      best_qvalue   <= '0;
      best_hops     <= '0;
      best_idx      <= '0;
    end else if (hb_reset) begin
      // Abort wins over everything, including a same-cycle start.
      state         <= IDLE;
      neighborCount <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      found         <= 1'b0;
      best_id       <= '0;
      best_qvalue   <= '0;
      best_hops     <= '0;
      best_idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            neighborCount <= '0;
            found         <= 1'b0;
            best_id       <= '0;
            best_qvalue   <= '0;
            best_hops     <= '0;
            best_idx      <= '0;
            if (neighbor_count == '0) begin
              // Empty table: report "nothing found" on the next cycle.
              state <= DONE;
              done  <= 1'b1;
            end else begin
              // The count is captured here so later changes cannot
              // stretch or shorten the walk.
              state    <= SCAN;
              busy     <= 1'b1;
              last_idx <= last_index(neighbor_count);
            end
          end
        end

        SCAN: begin
          if (replace) begin
            found       <= 1'b1;
            best_id     <= mNodeID;
            best_qvalue <= mNodeQValue;
            best_hops   <= mNodeHops;
            best_idx    <= neighborCount;
          end
          if (neighborCount == last_idx) begin
            state         <= DONE;
            busy          <= 1'b0;
            done          <= 1'b1;
            neighborCount <= '0;
          end else begin
            neighborCount <= neighborCount + IDX_WIDTH'(1);
          end
        end

        DONE: begin
          // start is deliberately not sampled here.
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state         <= IDLE;
          busy          <= 1'b0;
          done          <= 1'b0;
          neighborCount <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_next_hop_selector.sv
// Scoreboard bench for next_hop_selector: stimulus pushes expected results,
// a negedge monitor pops and compares whenever done pulses.
module tb_next_hop_selector;
  import neighbor_pkg::*;

  logic                  clk = 1'b0;
  logic                  nrst = 1'b0;
  logic                  start = 1'b0;
  logic                  hb_reset = 1'b0;
  logic [WORD_WIDTH-1:0] neighbor_count = '0;
  logic [WORD_WIDTH-1:0] min_energy = '0;
  logic [IDX_WIDTH-1:0]  neighborCount;
  logic                  tbl_valid;
  logic [WORD_WIDTH-1:0] mNodeID, mNodeHops, mNodeQValue, mNodeEnergy;
  logic                  busy, done, found;
  logic [WORD_WIDTH-1:0] best_id, best_qvalue, best_hops;
  logic [IDX_WIDTH-1:0]  best_idx;

  next_hop_selector dut (
    .clk(clk), .nrst(nrst), .start(start), .hb_reset(hb_reset),
    .neighbor_count(neighbor_count), .min_energy(min_energy),
    .neighborCount(neighborCount), .tbl_valid(tbl_valid),
    .mNodeID(mNodeID), .mNodeHops(mNodeHops), .mNodeQValue(mNodeQValue),
    .mNodeEnergy(mNodeEnergy), .busy(busy), .done(done), .found(found),
    .best_id(best_id), .best_qvalue(best_qvalue), .best_hops(best_hops),
    .best_idx(best_idx)
  );

  always #5 clk = ~clk;

  // Behavioural neighbour table, read combinationally.
  logic            tv [MAX_NEIGHBORS];
  logic [15:0]     tid[MAX_NEIGHBORS];
  logic [15:0]     th [MAX_NEIGHBORS];
  logic [15:0]     tq [MAX_NEIGHBORS];
  logic [15:0]     te [MAX_NEIGHBORS];

  always_comb begin
    tbl_valid   = tv[neighborCount];
    mNodeID     = tid[neighborCount];
    mNodeHops   = th[neighborCount];
    mNodeQValue = tq[neighborCount];
    mNodeEnergy = te[neighborCount];
  end

  typedef struct {
    logic        found;
    logic [15:0] id;
    logic [15:0] q;
    logic [15:0] hops;
    logic [4:0]  idx;
    int          edge_no;   // posedge that captures the done pulse
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (nrst && done) begin
      done_cnt <= done_cnt + 1;
      if (sbq.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("found",       found,       mon_e.found);
        check("best_id",     best_id,     mon_e.id);
        check("best_qvalue", best_qvalue, mon_e.q);
        check("best_hops",   best_hops,   mon_e.hops);
        check("best_idx",    best_idx,    mon_e.idx);
        check("done_edge",   cyc + 1,     mon_e.edge_no);
        check("busy_at_done", busy,       1'b0);
      end
    end
  end

  function automatic exp_t mk(input logic f, input logic [15:0] id,
                              input logic [15:0] q, input logic [15:0] h,
                              input logic [4:0] idx);
    exp_t e;
    e.found = f; e.id = id; e.q = q; e.hops = h; e.idx = idx; e.edge_no = 0;
    return e;
  endfunction

  // Reference: maximum Q over candidates, then minimum hops among those,
  // then the lowest index among what remains.
  function automatic exp_t model(input int n, input logic [15:0] emin);
    int best_q = -1;
    int min_h = 1 << 20;
    exp_t e;
    e = mk(1'b0, 16'h0, 16'h0, 16'h0, 5'd0);
    for (int i = 0; i < n; i++)
      if (tv[i] && te[i] >= emin && int'(tq[i]) > best_q) best_q = int'(tq[i]);
    if (best_q < 0) return e;
    for (int i = 0; i < n; i++)
      if (tv[i] && te[i] >= emin && int'(tq[i]) == best_q && int'(th[i]) < min_h)
        min_h = int'(th[i]);
    for (int i = n - 1; i >= 0; i--)
      if (tv[i] && te[i] >= emin && int'(tq[i]) == best_q && int'(th[i]) == min_h)
        e = mk(1'b1, tid[i], tq[i], th[i], 5'(i));
    return e;
  endfunction

  task automatic clear_table();
    for (int i = 0; i < MAX_NEIGHBORS; i++) begin
      tv[i] = 1'b0; tid[i] = 16'h0; th[i] = 16'h0; tq[i] = 16'h0; te[i] = 16'h0;
    end
  endtask

  task automatic set_entry(input int i, input logic v, input logic [15:0] id,
                           input logic [15:0] h, input logic [15:0] q,
                           input logic [15:0] en);
    tv[i] = v; tid[i] = id; th[i] = h; tq[i] = q; te[i] = en;
  endtask

  task automatic issue_start(input int cnt, input logic [15:0] emin,
                             input exp_t e, input int alt_cnt);
    int n;
    n = (cnt > MAX_NEIGHBORS) ? MAX_NEIGHBORS : cnt;
    @(negedge clk);
    neighbor_count = 16'(cnt);
    min_energy     = emin;
    start          = 1'b1;
    e.edge_no      = cyc + 1 + n + 1;   // start captured by edge cyc+1
    sbq.push_back(e);
    @(negedge clk);
    start          = 1'b0;
    neighbor_count = 16'(alt_cnt);
  endtask

  task automatic wait_done(input int budget, output int maxidx);
    int k = 0;
    maxidx = 0;
    while (sbq.size() != 0 && k < budget) begin
      @(negedge clk); #1;
      if (busy && int'(neighborCount) > maxidx) maxidx = int'(neighborCount);
      k++;
    end
    if (sbq.size() != 0) begin
      check("done_timeout", 32'd0, 32'd1);
      sbq.delete();
    end
  endtask

  task automatic run_scan(input int cnt, input logic [15:0] emin,
                          input exp_t e, input int alt_cnt);
    int m;
    issue_start(cnt, emin, e, alt_cnt);
    wait_done(40, m);
    repeat (3) @(negedge clk);
    #1;
    check("hold_found", found, e.found);
    check("hold_idx",   best_idx, e.idx);
    check("hold_q",     best_qvalue, e.q);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int m;
    int dc0;
    int k;
    exp_t e;
    clear_table();
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk); #1;
    check("rst_neighborCount", neighborCount, 5'd0);
    check("rst_busy",  busy,  1'b0);
    check("rst_done",  done,  1'b0);
    check("rst_found", found, 1'b0);
    check("rst_best_id", best_id, 16'h0);
    check("rst_best_q",  best_qvalue, 16'h0);
    check("rst_best_hops", best_hops, 16'h0);
    check("rst_best_idx",  best_idx, 5'd0);

    // Basic: highest Q wins.
    set_entry(0, 1, 16'h1000, 16'd1, 16'h0010, 16'h0100);
    set_entry(1, 1, 16'h1001, 16'd2, 16'h0040, 16'h0100);
    set_entry(2, 1, 16'h1002, 16'd3, 16'h0020, 16'h0100);
    run_scan(3, 16'h0080, mk(1, 16'h1001, 16'h0040, 16'd2, 5'd1), 3);

    // Energy floor excludes the highest Q.
    te[1] = 16'h0050;
    run_scan(3, 16'h0080, mk(1, 16'h1002, 16'h0020, 16'd3, 5'd2), 3);

    // Q tie broken by fewer hops, then by lower index.
    set_entry(0, 1, 16'h2000, 16'd3, 16'h0030, 16'h0100);
    set_entry(1, 1, 16'h2001, 16'd1, 16'h0010, 16'h0100);
    set_entry(2, 1, 16'h2002, 16'd1, 16'h0030, 16'h0100);
    run_scan(3, 16'h0080, mk(1, 16'h2002, 16'h0030, 16'd1, 5'd2), 3);
    th[0] = 16'd1;
    run_scan(3, 16'h0080, mk(1, 16'h2000, 16'h0030, 16'd1, 5'd0), 3);

    // Energy exactly at the floor qualifies.
    te[0] = 16'h0080;
    run_scan(3, 16'h0080, mk(1, 16'h2000, 16'h0030, 16'd1, 5'd0), 3);

    // Empty table, then all-invalid table.
    run_scan(0, 16'h0000, mk(0, 16'h0, 16'h0, 16'h0, 5'd0), 0);
    clear_table();
    for (int i = 0; i < 4; i++) set_entry(i, 0, 16'h3000 + 16'(i), 16'd1, 16'h0070, 16'hFFFF);
    run_scan(4, 16'h0000, mk(0, 16'h0, 16'h0, 16'h0, 5'd0), 4);

    // Heartbeat reset mid-scan aborts without a done pulse.
    clear_table();
    for (int i = 0; i < 6; i++) set_entry(i, 1, 16'h4000 + 16'(i), 16'd2, 16'h0010 + 16'(i), 16'h0100);
    dc0 = done_cnt;
    @(negedge clk);
    neighbor_count = 16'd6; min_energy = 16'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    #1;
    while (neighborCount != 5'd2 && k < 10) begin @(negedge clk); #1; k++; end
    check("hb_reached_idx2", neighborCount, 5'd2);
    hb_reset = 1'b1;
    @(negedge clk);
    hb_reset = 1'b0;
    #1;
    check("hb_busy", busy, 1'b0);
    check("hb_found", found, 1'b0);
    check("hb_best_q", best_qvalue, 16'h0);
    check("hb_neighborCount", neighborCount, 5'd0);
    // hb_reset beats a same-cycle start.
    @(negedge clk);
    hb_reset = 1'b1; start = 1'b1;
    @(negedge clk);
    hb_reset = 1'b0; start = 1'b0;
    #1;
    check("hb_start_busy", busy, 1'b0);
    repeat (10) @(negedge clk);
    check("hb_no_done", done_cnt, dc0);

    // start while busy and during DONE is ignored.
    dc0 = done_cnt;
    e = model(5, 16'h0);
    issue_start(5, 16'h0, e, 5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    #1;
    while (!done && k < 12) begin @(negedge clk); #1; k++; end
    start = 1'b1;                        // lands in the DONE cycle
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    check("one_done_only", done_cnt - dc0, 32'd1);
    check("idle_after_ignored", busy, 1'b0);

    // Count latched at start even if the input changes mid-scan.
    run_scan(5, 16'h0, model(5, 16'h0), 2);

    // Count clamped to the table depth.
    for (int i = 0; i < MAX_NEIGHBORS; i++)
      set_entry(i, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom_range(0, 3)),
                16'($urandom_range(0, 7) << 4), 16'($urandom_range(0, 4) * 64));
    tv[31] = 1'b1; tq[31] = 16'h0100; te[31] = 16'h0100;
    e = model(32, 16'h0040);
    issue_start(40, 16'h0040, e, 40);
    wait_done(45, m);
    check("clamp_max_idx", m, 32'd31);

    // Randomised scans.
    for (int t = 0; t < 25; t++) begin
      int cnt;
      logic [15:0] emin;
      for (int i = 0; i < MAX_NEIGHBORS; i++)
        set_entry(i, 1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom_range(0, 3)),
                  16'($urandom_range(0, 7) << 4), 16'($urandom_range(0, 4) * 64));
      cnt  = $urandom_range(0, 36);
      emin = 16'($urandom_range(0, 4) * 64);
      run_scan(cnt, emin, model((cnt > 32) ? 32 : cnt, emin), cnt);
    end

    // Asynchronous reset mid-scan.
    @(negedge clk);
    neighbor_count = 16'd8; min_energy = 16'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_neighborCount", neighborCount, 5'd0);
    check("arst_found", found, 1'b0);
    check("arst_best_id", best_id, 16'h0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    check("arst_stays_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
